// File: rtl/tile_raster_mapper_if.sv
// -----------------------------------------------------------------------------
// tile_raster_mapper_if
// Query-path bundle for tile_raster_mapper: a valid/ready request carrying a
// grid index, and a valid/ready response carrying the tile-centre coordinate.
//   master : game-logic side (drives req_*, rsp_ready)
//   slave  : mapper side     (drives req_ready, rsp_*)
// Parameters must match those of the tile_raster_mapper instance it connects.
// -----------------------------------------------------------------------------
interface tile_raster_mapper_if #(
   parameter int H_W     = 11,
   parameter int V_W     = 10,
   parameter int IDX_X_W = 7,
   parameter int IDX_Y_W = 6
);
   logic               req_valid;
   logic               req_ready;
   logic [IDX_X_W-1:0] req_x;
   logic [IDX_Y_W-1:0] req_y;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [H_W-1:0]     rsp_x;
   logic [V_W-1:0]     rsp_y;
   logic               rsp_err;

   modport master (
      output req_valid, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_x, rsp_y, rsp_err
   );

   modport slave (
      input  req_valid, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_x, rsp_y, rsp_err
   );
endinterface

// File: rtl/tile_raster_mapper.sv
// -----------------------------------------------------------------------------
// tile_raster_mapper
// Raster path: maps live VGA counters to grid cell index and in-tile sub-pixel
// offset through a 2-stage pipeline that advances on pix_en.
// Query path: maps a grid index to its tile-centre display coordinate through
// a single-entry valid/ready response register.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pix_en                pixel strobe (raster pipeline enable)
//   h_count, v_count      raster counters
//   cell_x, cell_y        grid cell of the pixel (0 outside the grid)
//   sub_x, sub_y          pixel offset inside the tile (0 outside the grid)
//   cell_valid            pixel lies inside the grid area
//   frame_start           one-strobe pulse for the first visible pixel
//   qry                   query bundle (tile_raster_mapper_if.slave)
// Optional macro TILE_MAP_SCROLL_EN adds scroll_x, scroll_y, scroll_load:
// a frame-synchronous cell scroll applied modulo the grid size.
// -----------------------------------------------------------------------------
module tile_raster_mapper #(
   parameter int H_W             = 11,
   parameter int V_W             = 10,
   parameter int H_VISIBLE_START = 336,
   parameter int V_VISIBLE_START = 27,
   parameter int TILE_SHIFT      = 4,
   parameter int GRID_W          = 80,
   parameter int GRID_H          = 50,
   parameter int IDX_X_W         = 7,
   parameter int IDX_Y_W         = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pix_en,
   input  logic [H_W-1:0]        h_count,
   input  logic [V_W-1:0]        v_count,
   output logic [IDX_X_W-1:0]    cell_x,
   output logic [IDX_Y_W-1:0]    cell_y,
   output logic [TILE_SHIFT-1:0] sub_x,
   output logic [TILE_SHIFT-1:0] sub_y,
   output logic                  cell_valid,
   output logic                  frame_start,
`ifdef TILE_MAP_SCROLL_EN
   input  logic [IDX_X_W-1:0]    scroll_x,
   input  logic [IDX_Y_W-1:0]    scroll_y,
   input  logic                  scroll_load,
`endif
   tile_raster_mapper_if.slave   qry
);

   localparam logic [H_W-1:0]     LP_HS  = H_W'(H_VISIBLE_START);
   localparam logic [V_W-1:0]     LP_VS  = V_W'(V_VISIBLE_START);
   localparam logic [H_W:0]       LP_GW1 = (H_W+1)'(GRID_W);
   localparam logic [V_W:0]       LP_GH1 = (V_W+1)'(GRID_H);
   localparam logic [IDX_X_W-1:0] LP_GWX = IDX_X_W'(GRID_W);
   localparam logic [IDX_Y_W-1:0] LP_GHY = IDX_Y_W'(GRID_H);
   localparam logic [H_W-1:0]     LP_HCTR = H_W'(H_VISIBLE_START + (1 << (TILE_SHIFT-1)) - 1);
   localparam logic [V_W-1:0]     LP_VCTR = V_W'(V_VISIBLE_START + (1 << (TILE_SHIFT-1)) - 1);

   // ---------------- raster stage 1 ----------------
   // One extra bit so counts before the visible start do not alias into the grid.
   logic [H_W:0] w_rel_x;
   logic [V_W:0] w_rel_y;
   logic         w_in_x, w_in_y, w_first;

   assign w_rel_x = {1'b0, h_count} - {1'b0, LP_HS};
   assign w_rel_y = {1'b0, v_count} - {1'b0, LP_VS};
   assign w_in_x  = (h_count >= LP_HS) && ((w_rel_x >> TILE_SHIFT) < LP_GW1);
   assign w_in_y  = (v_count >= LP_VS) && ((w_rel_y >> TILE_SHIFT) < LP_GH1);
   assign w_first = (h_count == LP_HS) && (v_count == LP_VS);

   logic [H_W-1:0] r_s1_rel_x;
   logic [V_W-1:0] r_s1_rel_y;
   logic           r_s1_in_x, r_s1_in_y, r_s1_first;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_rel_x <= '0;
         r_s1_rel_y <= '0;
         r_s1_in_x  <= 1'b0;
         r_s1_in_y  <= 1'b0;
         r_s1_first <= 1'b0;
      end else if (pix_en) begin
         r_s1_rel_x <= w_rel_x[H_W-1:0];
         r_s1_rel_y <= w_rel_y[V_W-1:0];
         r_s1_in_x  <= w_in_x;
         r_s1_in_y  <= w_in_y;
         r_s1_first <= w_first;
      end
   end

   // ---------------- raster stage 2 ----------------
   logic [IDX_X_W-1:0] w_cx_raw, w_cx;
   logic [IDX_Y_W-1:0] w_cy_raw, w_cy;
   logic               w_valid;

   assign w_cx_raw = r_s1_rel_x[TILE_SHIFT +: IDX_X_W];
   assign w_cy_raw = r_s1_rel_y[TILE_SHIFT +: IDX_Y_W];
   assign w_valid  = r_s1_in_x && r_s1_in_y;

`ifdef TILE_MAP_SCROLL_EN
   logic [IDX_X_W-1:0] r_pend_sx, r_act_sx, w_sx_eff;
   logic [IDX_Y_W-1:0] r_pend_sy, r_act_sy, w_sy_eff;
   logic [IDX_X_W:0]   w_sum_x;
   logic [IDX_Y_W:0]   w_sum_y;
   logic               w_swap;

   // Pending scroll becomes active on the frame_start strobe; the first pixel
   // of that frame already uses the new value so the whole frame is consistent.
   assign w_swap   = pix_en && r_s1_first;
   assign w_sx_eff = w_swap ? r_pend_sx : r_act_sx;
   assign w_sy_eff = w_swap ? r_pend_sy : r_act_sy;
   assign w_sum_x  = {1'b0, w_cx_raw} + {1'b0, w_sx_eff};
   assign w_sum_y  = {1'b0, w_cy_raw} + {1'b0, w_sy_eff};
   assign w_cx     = (w_sum_x >= {1'b0, LP_GWX}) ? IDX_X_W'(w_sum_x - {1'b0, LP_GWX})
                                                 : w_sum_x[IDX_X_W-1:0];
   assign w_cy     = (w_sum_y >= {1'b0, LP_GHY}) ? IDX_Y_W'(w_sum_y - {1'b0, LP_GHY})
                                                 : w_sum_y[IDX_Y_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_sx <= '0;
         r_pend_sy <= '0;
         r_act_sx  <= '0;
         r_act_sy  <= '0;
      end else begin
         if (scroll_load) begin
            r_pend_sx <= (scroll_x >= LP_GWX) ? scroll_x - LP_GWX : scroll_x;
            r_pend_sy <= (scroll_y >= LP_GHY) ? scroll_y - LP_GHY : scroll_y;
         end
         if (w_swap) begin
            r_act_sx <= r_pend_sx;
            r_act_sy <= r_pend_sy;
         end
      end
   end
`else
   assign w_cx = w_cx_raw;
   assign w_cy = w_cy_raw;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cell_x      <= '0;
         cell_y      <= '0;
         sub_x       <= '0;
         sub_y       <= '0;
         cell_valid  <= 1'b0;
         frame_start <= 1'b0;
      end else if (pix_en) begin
         cell_x      <= w_valid ? w_cx : '0;
         cell_y      <= w_valid ? w_cy : '0;
         sub_x       <= w_valid ? r_s1_rel_x[TILE_SHIFT-1:0] : '0;
         sub_y       <= w_valid ? r_s1_rel_y[TILE_SHIFT-1:0] : '0;
         cell_valid  <= w_valid;
         frame_start <= r_s1_first;
      end
   end

   // ---------------- query path ----------------
   // r_rdy_en keeps req_ready low during reset and for the first cycle after.
   logic           r_rdy_en, r_rsp_valid, r_rsp_err;
   logic [H_W-1:0] r_rsp_x, w_q_x;
   logic [V_W-1:0] r_rsp_y, w_q_y;
   logic           w_accept, w_q_err;

   assign qry.req_ready = r_rdy_en && (!r_rsp_valid || qry.rsp_ready);
   assign w_accept      = qry.req_valid && qry.req_ready;
   assign w_q_err       = (qry.req_x >= LP_GWX) || (qry.req_y >= LP_GHY);
   assign w_q_x         = (H_W'(qry.req_x) << TILE_SHIFT) + LP_HCTR;
   assign w_q_y         = (V_W'(qry.req_y) << TILE_SHIFT) + LP_VCTR;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy_en    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_x     <= '0;
         r_rsp_y     <= '0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_q_err;
            r_rsp_x     <= w_q_err ? '0 : w_q_x;
            r_rsp_y     <= w_q_err ? '0 : w_q_y;
         end else if (qry.rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign qry.rsp_valid = r_rsp_valid;
   assign qry.rsp_err   = r_rsp_err;
   assign qry.rsp_x     = r_rsp_x;
   assign qry.rsp_y     = r_rsp_y;

endmodule
